// File: rtl/axil_csr_bridge_v2.sv
// Single-clock AXI4-Lite slave to CSR-bus bridge. One CSR access in flight, read/write
// round-robin arbitration, byte strobes, fixed CSR read latency, SLVERR beyond g_addr_limit.
module axil_csr_bridge_v2 #(
  parameter int unsigned g_csr_addr_bits = 16,
  parameter int unsigned g_read_latency  = 1,
  parameter int unsigned g_addr_limit    = 2 ** g_csr_addr_bits
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                s_axil_AWADDR,
  input  logic                       s_axil_AWVALID,
  output logic                       s_axil_AWREADY,
  input  logic [31:0]                s_axil_WDATA,
  input  logic [3:0]                 s_axil_WSTRB,
  input  logic                       s_axil_WVALID,
  output logic                       s_axil_WREADY,
  output logic [1:0]                 s_axil_BRESP,
  output logic                       s_axil_BVALID,
  input  logic                       s_axil_BREADY,
  input  logic [31:0]                s_axil_ARADDR,
  input  logic                       s_axil_ARVALID,
  output logic                       s_axil_ARREADY,
  output logic [31:0]                s_axil_RDATA,
  output logic [1:0]                 s_axil_RRESP,
  output logic                       s_axil_RVALID,
  input  logic                       s_axil_RREADY,
  output logic [g_csr_addr_bits-1:0] csr_adr_o,
  output logic [31:0]                csr_dat_o,
  output logic [3:0]                 csr_sel_o,
  output logic                       csr_wr_o,
  output logic                       csr_rd_o,
  input  logic [31:0]                csr_dat_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StWresp = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StRresp = 3'd4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [2:0] ReadLat    = 3'(g_read_latency);

  logic [2:0]                 state_q, state_d;
  logic                       aw_full_q, aw_full_d;
  logic [31:0]                aw_addr_q, aw_addr_d;
  logic                       w_full_q, w_full_d;
  logic [31:0]                w_data_q, w_data_d;
  logic [3:0]                 w_strb_q, w_strb_d;
  logic                       last_wr_q, last_wr_d;
  logic [g_csr_addr_bits-1:0] adr_q, adr_d;
  logic [31:0]                dat_q, dat_d;
  logic [3:0]                 sel_q, sel_d;
  logic                       oor_q, oor_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [31:0]                rdata_q, rdata_d;

  logic        aw_hs, w_hs, wr_rdy, rd_req, grant_wr, grant_rd;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  function automatic logic out_of_range(input logic [31:0] addr);
    return {2'b00, addr[31:2]} >= g_addr_limit;
  endfunction

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], s_axil_ARADDR[1:0]};

  // A channel handshaking this cycle counts as already held, so a write whose last
  // half arrives in IDLE is granted at once rather than one cycle later.
  always_comb begin
    s_axil_AWREADY = !rst_i && !aw_full_q;
    s_axil_WREADY  = !rst_i && !w_full_q;
    aw_hs   = s_axil_AWVALID && s_axil_AWREADY;
    w_hs    = s_axil_WVALID && s_axil_WREADY;
    wr_addr = aw_full_q ? aw_addr_q : s_axil_AWADDR;
    wr_data = w_full_q ? w_data_q : s_axil_WDATA;
    wr_strb = w_full_q ? w_strb_q : s_axil_WSTRB;
    wr_rdy  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    rd_req  = s_axil_ARVALID;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle && !rst_i) begin
      if (wr_rdy && rd_req) begin
        grant_wr = !last_wr_q;
        grant_rd = last_wr_q;
      end else begin
        grant_wr = wr_rdy;
        grant_rd = rd_req;
      end
    end
    s_axil_ARREADY = grant_rd;
  end

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    last_wr_d = last_wr_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    oor_d     = oor_q;
    cnt_d     = cnt_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_WDATA;
      w_strb_d = s_axil_WSTRB;
    end

    case (state_q)
      StIdle: begin
        if (grant_wr) begin
          state_d   = StWrite;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          last_wr_d = 1'b1;
          adr_d     = wr_addr[g_csr_addr_bits+1:2];
          dat_d     = wr_data;
          sel_d     = wr_strb;
          oor_d     = out_of_range(wr_addr);
          bresp_d   = out_of_range(wr_addr) ? RespSlvErr : RespOkay;
        end else if (grant_rd) begin
          state_d   = StRead;
          last_wr_d = 1'b0;
          adr_d     = s_axil_ARADDR[g_csr_addr_bits+1:2];
          oor_d     = out_of_range(s_axil_ARADDR);
          cnt_d     = 3'd0;
        end
      end
      StWrite: state_d = StWresp;
      StWresp: begin
        if (s_axil_BREADY) state_d = StIdle;
      end
      StRead: begin
        // Out-of-range reads still wait the full latency so response timing is uniform.
        if (cnt_q == ReadLat) begin
          rdata_d = oor_q ? 32'h0 : csr_dat_i;
          rresp_d = oor_q ? RespSlvErr : RespOkay;
          state_d = StRresp;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRresp: begin
        if (s_axil_RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      last_wr_q <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      oor_q     <= 1'b0;
      cnt_q     <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      last_wr_q <= last_wr_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      oor_q     <= oor_d;
      cnt_q     <= cnt_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    csr_adr_o     = adr_q;
    csr_dat_o     = dat_q;
    csr_sel_o     = sel_q;
    csr_wr_o      = (state_q == StWrite) && !oor_q;
    csr_rd_o      = (state_q == StRead) && (cnt_q == 3'd0) && !oor_q;
    s_axil_BVALID = (state_q == StWresp);
    s_axil_BRESP  = bresp_q;
    s_axil_RVALID = (state_q == StRresp);
    s_axil_RRESP  = rresp_q;
    s_axil_RDATA  = rdata_q;
  end

endmodule

// File: tb/tb_axil_csr_bridge_v2.sv
// Bench for axil_csr_bridge_v2: directed and random AXI-Lite traffic against a word-array
// reference model and a latency-accurate CSR slave model.
module tb_axil_csr_bridge_v2;

  localparam int unsigned AddrBits = 16;
  localparam int unsigned Lat      = 3;
  localparam int unsigned Limit    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         awaddr, wdata, araddr, rdata, csr_dat_out;
  logic [31:0]         csr_dat_in = '0;
  logic [3:0]          wstrb, csr_sel;
  logic                awvalid, awready, wvalid, wready, bvalid, bready;
  logic                arvalid, arready, rvalid, rready, csr_wr, csr_rd;
  logic [1:0]          bresp, rresp;
  logic [AddrBits-1:0] csr_adr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] ref_mem [Limit] = '{default: '0};
  logic [31:0] slv_mem [Limit] = '{default: '0};

  int                  wr_count = 0, rd_count = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  int                  rd_pend_cyc = -100;
  logic [AddrBits-1:0] last_wr_adr = '0, last_rd_adr = '0, rd_pend_adr = '0;
  logic [31:0]         last_wr_dat = '0;
  logic [3:0]          last_wr_sel = '0;
  bit                  op_log[$];

  axil_csr_bridge_v2 #(
    .g_csr_addr_bits(AddrBits),
    .g_read_latency (Lat),
    .g_addr_limit   (Limit)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .s_axil_AWADDR (awaddr),
    .s_axil_AWVALID(awvalid),
    .s_axil_AWREADY(awready),
    .s_axil_WDATA  (wdata),
    .s_axil_WSTRB  (wstrb),
    .s_axil_WVALID (wvalid),
    .s_axil_WREADY (wready),
    .s_axil_BRESP  (bresp),
    .s_axil_BVALID (bvalid),
    .s_axil_BREADY (bready),
    .s_axil_ARADDR (araddr),
    .s_axil_ARVALID(arvalid),
    .s_axil_ARREADY(arready),
    .s_axil_RDATA  (rdata),
    .s_axil_RRESP  (rresp),
    .s_axil_RVALID (rvalid),
    .s_axil_RREADY (rready),
    .csr_adr_o     (csr_adr),
    .csr_dat_o     (csr_dat_out),
    .csr_sel_o     (csr_sel),
    .csr_wr_o      (csr_wr),
    .csr_rd_o      (csr_rd),
    .csr_dat_i     (csr_dat_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR slave: log strobes mid-cycle, apply byte-enabled writes, remember read requests.
  always @(negedge clk) begin
    if (csr_wr === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      last_wr_adr = csr_adr;
      last_wr_dat = csr_dat_out;
      last_wr_sel = csr_sel;
      for (int b = 0; b < 4; b++)
        if (csr_sel[b]) slv_mem[csr_adr[3:0]][8*b +: 8] = csr_dat_out[8*b +: 8];
      op_log.push_back(1'b1);
    end
    if (csr_rd === 1'b1) begin
      rd_count++;
      last_rd_cyc = cyc;
      last_rd_adr = csr_adr;
      rd_pend_cyc = cyc;
      rd_pend_adr = csr_adr;
      op_log.push_back(1'b0);
    end
  end

  // Read data is valid only in the cycle Lat after csr_rd; garbage at all other times.
  always @(posedge clk) begin
    #1;
    if (cyc == rd_pend_cyc + Lat) csr_dat_in = slv_mem[rd_pend_adr[3:0]];
    else csr_dat_in = $urandom;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lag, input int w_lag,
                           input int b_lag, input bit chk_t);
    bit aw_done = 0, w_done = 0, got_b = 0, inr;
    int t = 0, hs_cyc = 0, b_cyc = 0, wr0;
    inr = ({2'b00, addr[31:2]} < Limit);
    wr0 = wr_count;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_lag);
      wvalid  = !w_done && (t >= w_lag);
      @(negedge clk);
      if (awvalid && awready) begin aw_done = 1; hs_cyc = cyc; end
      if (wvalid && wready) begin w_done = 1; hs_cyc = cyc; end
      step();
      t++;
    end
    awvalid = 0;
    wvalid  = 0;
    check_val("wr_handshakes", 64'({aw_done, w_done}), 64'(2'b11));
    bready = 0;
    for (int i = 0; i < 40 && !got_b; i++) begin
      @(negedge clk);
      if (bvalid) begin got_b = 1; b_cyc = cyc; end
      else step();
    end
    check_val("bvalid_seen", 64'(got_b), 64'd1);
    if (got_b) begin
      if (chk_t) check_val("bvalid_cycle", 64'(b_cyc), 64'(hs_cyc + 2));
      for (int i = 0; i < b_lag; i++) begin
        step();
        @(negedge clk);
        check_val("b_hold", 64'({bvalid, bresp}), 64'({1'b1, inr ? 2'b00 : 2'b10}));
      end
      check_val("bresp", 64'(bresp), 64'(inr ? 2'b00 : 2'b10));
      bready = 1;
      step();
      bready = 0;
    end
    check_val("csr_wr_count", 64'(wr_count - wr0), 64'(inr ? 1 : 0));
    if (inr) begin
      check_val("csr_wr_fields", 64'({last_wr_adr, last_wr_dat, last_wr_sel}),
                64'({addr[AddrBits+1:2], data, strb}));
      if (chk_t) check_val("csr_wr_cycle", 64'(last_wr_cyc), 64'(hs_cyc + 1));
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int r_lag, input bit chk_t);
    bit done = 0, got_r = 0, inr;
    int t = 0, hs_cyc = 0, r_cyc = 0, rd0;
    logic [31:0] exp_d;
    inr = ({2'b00, addr[31:2]} < Limit);
    rd0 = rd_count;
    araddr = addr;
    while (!done && t < 60) begin
      arvalid = 1;
      @(negedge clk);
      if (arready) begin done = 1; hs_cyc = cyc; end
      step();
      t++;
    end
    arvalid = 0;
    check_val("ar_handshake", 64'(done), 64'd1);
    rready = 0;
    for (int i = 0; i < 40 && !got_r; i++) begin
      @(negedge clk);
      if (rvalid) begin got_r = 1; r_cyc = cyc; end
      else step();
    end
    check_val("rvalid_seen", 64'(got_r), 64'd1);
    if (got_r) begin
      exp_d = inr ? ref_mem[addr[5:2]] : 32'h0;
      if (chk_t) check_val("rvalid_cycle", 64'(r_cyc), 64'(hs_cyc + 2 + Lat));
      check_val("rresp_rdata", 64'({rresp, rdata}), 64'({inr ? 2'b00 : 2'b10, exp_d}));
      for (int i = 0; i < r_lag; i++) begin
        step();
        @(negedge clk);
        check_val("r_hold", 64'({rvalid, rresp, rdata}),
                  64'({1'b1, inr ? 2'b00 : 2'b10, exp_d}));
      end
      rready = 1;
      step();
      rready = 0;
    end
    check_val("csr_rd_count", 64'(rd_count - rd0), 64'(inr ? 1 : 0));
    if (inr && chk_t)
      check_val("csr_rd_fields", 64'({last_rd_cyc, last_rd_adr}),
                64'({32'(hs_cyc + 1), addr[AddrBits+1:2]}));
  endtask

  // Holds every request valid through reset; all readies and outputs must stay zero.
  task automatic do_reset(input int n);
    rst     = 1;
    awvalid = 1;
    wvalid  = 1;
    arvalid = 1;
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge clk);
      check_val("rst_ready", 64'({awready, wready, arready}), 64'd0);
      check_val("rst_outs", 64'({bvalid, rvalid, bresp, rresp, csr_wr, csr_rd, csr_sel, csr_adr}),
                64'd0);
      check_val("rst_data", 64'({rdata, csr_dat_out}), 64'd0);
    end
    step();
    rst     = 0;
    awvalid = 0;
    wvalid  = 0;
    arvalid = 0;
    @(negedge clk);
    check_val("post_rst_ready", 64'({awready, wready, arready}), 64'(3'b110));
    step();
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int  log0;
    bit  got, seen;
    rst = 1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 32'h10; wdata = 32'h0; wstrb = 4'hf; araddr = 32'h0;

    do_reset(3);

    // W ahead of AW, then a long B stall.
    write_txn(32'h10, 32'hCAFE_F00D, 4'h5, 2, 0, 5, 1);
    write_txn(32'h8, 32'h1234_5678, 4'hF, 0, 0, 0, 1);
    read_txn(32'h8, 2, 1);
    read_txn(32'h10, 0, 1);

    write_txn(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 1);
    read_txn(32'h44, 1, 1);
    write_txn(32'h14, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, 1);

    // Last grant was a write; reset must hand the first tie back to the write side.
    do_reset(2);
    log0 = op_log.size();
    fork
      begin
        write_txn(32'h20, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0);
        write_txn(32'h24, 32'hA5A5_0002, 4'hF, 0, 0, 0, 0);
      end
      begin
        read_txn(32'h30, 0, 0);
        read_txn(32'h34, 0, 0);
      end
    join
    check_val("grant_count", 64'(op_log.size() - log0), 64'd4);
    if (op_log.size() - log0 == 4)
      check_val("grant_order", 64'({op_log[log0], op_log[log0+1], op_log[log0+2], op_log[log0+3]}),
                64'(4'b1010));

    // Reset in the cycle after csr_rd drops the read with no response.
    araddr  = 32'h8;
    arvalid = 1;
    got     = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (arready) got = 1;
      step();
    end
    arvalid = 0;
    check_val("mid_rst_ar", 64'(got), 64'd1);
    @(negedge clk);
    check_val("mid_rst_csr_rd", 64'(csr_rd), 64'd1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check_val("mid_rst_drop", 64'({csr_rd, rvalid}), 64'd0);
    seen   = 0;
    rready = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      if (rvalid) seen = 1;
    end
    rready = 0;
    check_val("mid_rst_no_rvalid", 64'(seen), 64'd0);
    step();
    read_txn(32'h8, 0, 1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int unsigned w;
      w = $urandom_range(0, 19);
      a = 32'(w) << 2;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      a[1:0] = 2'($urandom);
      if ($urandom_range(0, 1) == 1)
        write_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), 1);
      else
        read_txn(a, $urandom_range(0, 2), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
